// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and the stage that feeds it.
//   - ALU op codes carried on the 4-bit ctrl bus
//   - the op code a pipeline bubble carries (ADD, so an idle ALU does harmless work)
//   - default datapath and register-address widths
package alu_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int RW_DEFAULT = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_EQ  = 4'b1101;

    localparam logic [3:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
// Resolves one ALU source operand from the registered register-file data and
// the two in-flight results further down the pipe.
// Ports:
//   reg_addr        register number of the operand (r0 never forwards)
//   reg_data        register-file value captured at ID
//   exmem_*         EX/MEM result source (write enable, destination, value)
//   memwb_*         MEM/WB result source (write enable, destination, value)
//   operand         resolved value; EX/MEM wins over MEM/WB since it is younger
module fwd_mux
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic [RW-1:0] reg_addr,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] operand
);

    always_comb begin
        operand = reg_data;
        if (reg_addr != '0) begin
            if (exmem_reg_write && (exmem_rd == reg_addr)) begin
                operand = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == reg_addr)) begin
                operand = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register in front of the ALU. Captures the decoded fields,
// sign/zero-extends the immediate, resolves operands and flags load-use hazards.
// Build option: ID_EX_FWD_EN
//   defined   - EX/MEM and MEM/WB results forward into alu_x/alu_y/ex_store_data;
//               hazard_stall covers only load-use.
//   undefined - forwarding inputs are ignored; hazard_stall also fires on any RAW
//               match against the EX or EX/MEM destination (MEM/WB is covered by
//               write-before-read in the register file).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decoded instruction from the ID stage
//   stall, flush                 downstream freeze / squash of the incoming slot
//   exmem_*, memwb_*             forwarding sources
//   hazard_stall                 combinational hold request to IF/ID
//   ex_valid, alu_ctrl, alu_sa,
//   ex_rd, ex_reg_write,
//   ex_mem_read, ex_mem_write    registered fields
//   alu_x, alu_y, ex_store_data  resolved operands
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_ctrl,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic [4:0]    id_sa,
    input  logic          id_use_imm,
    input  logic          id_imm_zext,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          stall,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic [4:0]    alu_sa,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
);

    logic [RW-1:0] ex_rs_addr;
    logic [RW-1:0] ex_rt_addr;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm32;
    logic          ex_use_imm;

    logic [DW-1:0] imm_ext;
    logic [DW-1:0] rs_value;
    logic [DW-1:0] rt_value;

    logic          rs_hit_ex;
    logic          rt_hit_ex;
    logic          load_use;

    assign imm_ext = id_imm_zext ? {{(DW-16){1'b0}}, id_imm}
                                 : {{(DW-16){id_imm[15]}}, id_imm};

    // rt only counts as a source when y is not taken from the immediate.
    assign rs_hit_ex = (id_rs_addr == ex_rd);
    assign rt_hit_ex = !id_use_imm && (id_rt_addr == ex_rd);
    assign load_use  = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                       && (rs_hit_ex || rt_hit_ex);

`ifdef ID_EX_FWD_EN
    assign hazard_stall = load_use;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .reg_addr        (ex_rs_addr),
        .reg_data        (ex_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand         (rs_value)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .reg_addr        (ex_rt_addr),
        .reg_data        (ex_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand         (rt_value)
    );
`else
    logic raw_ex;
    logic raw_exmem;
    logic unused_fwd;

    // Without forwarding every in-flight writer that ID reads from must drain first.
    assign raw_ex    = id_valid && ex_reg_write && (ex_rd != '0)
                       && (rs_hit_ex || rt_hit_ex);
    assign raw_exmem = id_valid && exmem_reg_write && (exmem_rd != '0)
                       && ((id_rs_addr == exmem_rd)
                           || (!id_use_imm && (id_rt_addr == exmem_rd)));
    assign hazard_stall = load_use || raw_ex || raw_exmem;

    assign rs_value = ex_rs_data;
    assign rt_value = ex_rt_data;

    assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                          ex_rs_addr, ex_rt_addr};
`endif

    assign alu_x         = rs_value;
    assign alu_y         = ex_use_imm ? ex_imm32 : rt_value;
    assign ex_store_data = rt_value;

    // Reset, flush and an unstalled hazard all load the same all-zero bubble;
    // stall alone freezes the register, otherwise the ID slot is captured.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && hazard_stall)) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= ALU_BUBBLE;
            ex_rs_addr   <= '0;
            ex_rt_addr   <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm32     <= '0;
            alu_sa       <= '0;
            ex_use_imm   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            alu_ctrl     <= id_alu_ctrl;
            ex_rs_addr   <= id_rs_addr;
            ex_rt_addr   <= id_rt_addr;
            ex_rd        <= id_rd_addr;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_imm32     <= imm_ext;
            alu_sa       <= id_sa;
            ex_use_imm   <= id_use_imm;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed walk through the ID/EX stage behaviours followed by randomized
// traffic; every cycle the DUT is compared against an instruction-level model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [3:0]    id_alu_ctrl;
    logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic [DW-1:0] id_rs_data, id_rt_data;
    logic [15:0]   id_imm;
    logic [4:0]    id_sa;
    logic          id_use_imm, id_imm_zext;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          stall, flush;
    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;
    logic          hazard_stall, ex_valid;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_x, alu_y, ex_store_data;
    logic [4:0]    alu_sa;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_sa(id_sa),
        .id_use_imm(id_use_imm), .id_imm_zext(id_imm_zext),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sa(alu_sa), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // Model: the instruction currently sitting in EX, as plain fields.
    typedef struct {
        bit          valid;
        bit [3:0]    op;
        bit [4:0]    rs, rt, rd, sa;
        bit [31:0]   rs_val, rt_val, imm;
        bit          use_imm, wr, mrd, mwr;
    } instr_t;

    instr_t m;
    bit     model_ready = 0;

    function automatic bit [31:0] extend(input bit [15:0] v, input bit zext);
        if (zext || v < 16'h8000) return 32'(v);
        return 32'(v) + 32'hFFFF_0000;
    endfunction

    function automatic bit reads(input bit [4:0] r);
        return r != 0 && (id_rs_addr == r || (!id_use_imm && id_rt_addr == r));
    endfunction

    function automatic bit model_hazard();
        bit h;
        h = id_valid && m.valid && m.mrd && reads(m.rd);
`ifndef ID_EX_FWD_EN
        h = h || (id_valid && m.wr && reads(m.rd))
              || (id_valid && exmem_reg_write && reads(exmem_rd));
`endif
        return h;
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] v);
`ifdef ID_EX_FWD_EN
        if (r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
        if (r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        instr_t nxt;
        nxt = '{default: 0};
        if (rst || flush) m = nxt;
        else if (!stall) begin
            if (model_hazard()) m = nxt;
            else begin
                nxt.valid = id_valid;   nxt.op = id_alu_ctrl;
                nxt.rs = id_rs_addr;    nxt.rt = id_rt_addr;   nxt.rd = id_rd_addr;
                nxt.sa = id_sa;         nxt.rs_val = id_rs_data; nxt.rt_val = id_rt_data;
                nxt.imm = extend(id_imm, id_imm_zext);
                nxt.use_imm = id_use_imm; nxt.wr = id_reg_write;
                nxt.mrd = id_mem_read;  nxt.mwr = id_mem_write;
                m = nxt;
            end
        end
        model_ready = 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            bit [31:0] xs, ts;
            xs = operand(m.rs, m.rs_val);
            ts = operand(m.rt, m.rt_val);
            checkOutput("m_hazard", 32'(hazard_stall), 32'(model_hazard()));
            checkOutput("m_valid", 32'(ex_valid), 32'(m.valid));
            checkOutput("m_ctrl", 32'(alu_ctrl), 32'(m.op));
            checkOutput("m_x", alu_x, xs);
            checkOutput("m_y", alu_y, m.use_imm ? m.imm : ts);
            checkOutput("m_sa", 32'(alu_sa), 32'(m.sa));
            checkOutput("m_store", ex_store_data, ts);
            checkOutput("m_rd", 32'(ex_rd), 32'(m.rd));
            checkOutput("m_wr", 32'(ex_reg_write), 32'(m.wr));
            checkOutput("m_mrd", 32'(ex_mem_read), 32'(m.mrd));
            checkOutput("m_mwr", 32'(ex_mem_write), 32'(m.mwr));
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [15:0] imm,
                                 input logic ui, input logic zx, input logic wr,
                                 input logic mr, input logic mw);
        id_valid = v;       id_alu_ctrl = op;
        id_rs_addr = rs;    id_rt_addr = rt;   id_rd_addr = rd;
        id_rs_data = rsd;   id_rt_data = rtd;
        id_imm = imm;       id_sa = 5'd0;
        id_use_imm = ui;    id_imm_zext = zx;
        id_reg_write = wr;  id_mem_read = mr;  id_mem_write = mw;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset_x", alu_x, 32'd0);
        checkOutput("reset_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("reset_hazard", 32'(hazard_stall), 32'd0);

        // ADD r3 = r1 + r2
        nextCycle();
        rst = 0;
        applyStimulus(1, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 0, 0, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        stall = 1;
        @(negedge clk);
        checkOutput("add_x", alu_x, 32'd5);
        checkOutput("add_y", alu_y, 32'd7);
        checkOutput("add_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("add_valid", 32'(ex_valid), 32'd1);

        // forwarding priority, then r0 never forwards
        exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'd100;
        memwb_reg_write = 1; memwb_rd = 5'd1; memwb_result = 32'd200;
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_exmem", alu_x, 32'd100);
`else
        checkOutput("fwd_exmem", alu_x, 32'd5);
`endif
        exmem_rd = 5'd0;
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_memwb", alu_x, 32'd200);
`else
        checkOutput("fwd_memwb", alu_x, 32'd5);
`endif

        // LW r4 then SUB using r4
        nextCycle();
        stall = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        applyStimulus(1, 4'b0000, 5'd1, 5'd0, 5'd4, 32'd9, 32'd0, 16'd8, 1, 0, 1, 1, 0);
        nextCycle();
        applyStimulus(1, 4'b0001, 5'd4, 5'd5, 5'd6, 32'd11, 32'd3, 16'h0, 0, 0, 1, 0, 0);
        #1;
        checkOutput("lu_hazard", 32'(hazard_stall), 32'd1);
        nextCycle();
        checkOutput("lu_bubble", 32'(ex_valid), 32'd0);
        checkOutput("lu_hazard_drop", 32'(hazard_stall), 32'd0);
        nextCycle();
        checkOutput("sub_valid", 32'(ex_valid), 32'd1);
        checkOutput("sub_ctrl", 32'(alu_ctrl), 32'd1);
        checkOutput("sub_x", alu_x, 32'd11);

        // immediate extension
        applyStimulus(1, 4'b0000, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h8000, 1, 0, 1, 0, 0);
        nextCycle();
        checkOutput("imm_sext", alu_y, 32'hFFFF_8000);
        applyStimulus(1, 4'b0000, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h8000, 1, 1, 1, 0, 0);
        nextCycle();
        checkOutput("imm_zext", alu_y, 32'h0000_8000);

        // flush beats stall
        applyStimulus(1, 4'b0011, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0, 0, 0, 1, 1, 1);
        stall = 1; flush = 1;
        nextCycle();
        stall = 0; flush = 0;
        applyStimulus(0, 4'd0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        checkOutput("flush_valid", 32'(ex_valid), 32'd0);
        checkOutput("flush_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("flush_wr", 32'(ex_reg_write), 32'd0);
        checkOutput("flush_mrd", 32'(ex_mem_read), 32'd0);
        checkOutput("flush_mwr", 32'(ex_mem_write), 32'd0);

        // randomized traffic over a small register set so matches are common
        for (int i = 0; i < 800; i++) begin
            nextCycle();
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            applyStimulus($urandom_range(0, 4) != 0, 4'($urandom),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), $urandom, $urandom, 16'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 2) == 0, 1'($urandom));
            id_sa = 5'($urandom);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = $urandom;
        end
        nextCycle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
